// File: rtl/awg_pkg.sv
// Shared constants for the AWG command sequencer: FSM encodings, register map,
// rejection causes and the power-on configuration.
package awg_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_LO   = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;

    localparam logic [1:0] ADDR_WAVE   = 2'd0;
    localparam logic [1:0] ADDR_FREQ   = 2'd1;
    localparam logic [1:0] ADDR_AMP    = 2'd2;
    localparam logic [1:0] ADDR_OFFSET = 2'd3;

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_FORMAT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef struct packed {
        logic [1:0]  wave;
        logic [15:0] freq;
        logic [9:0]  amp;
        logic [9:0]  offset;
    } cfg_t;

    localparam cfg_t CFG_RST = '{wave: 2'd0, freq: 16'h0001, amp: 10'h3FF, offset: 10'h200};

endpackage

// File: rtl/awg_byte_timer.sv
// Inter-byte watchdog: counts idle cycles inside a frame and flags the cycle
// on which the next edge would exceed the allowed gap.
module awg_byte_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds cycles elapsed since the last byte; the edge after LAST is the TIMEOUT_CYCLES-th
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/awg_cmd_sequencer.sv
// Framed UART command sequencer: assembles SYNC/CMD/HI/LO/CHK frames, validates them
// and stages writes in a shadow bank that commits atomically to the live config.
module awg_cmd_sequencer
    import awg_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_data,
    input  logic        data_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    logic [2:0] state;
    logic [7:0] cmd_q;
    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic [7:0] chk_acc;
    cfg_t       shadow;
    cfg_t       live;
    cfg_t       shadow_nxt;
    logic       sum_bad;
    logic       fmt_bad;
    logic       expired;

    function automatic logic frame_format_bad(input logic [7:0] cmd, input logic [7:0] hi,
                                              input logic [7:0] lo);
        logic range_bad;
        range_bad = 1'b0;
        case (cmd[1:0])
            ADDR_WAVE:   range_bad = (hi != 8'h00) || (lo[7:2] != 6'd0);
            ADDR_FREQ:   range_bad = ({hi, lo} == 16'h0000);
            default:     range_bad = (hi[7:2] != 6'd0);
        endcase
        return (cmd[5:2] != 4'd0) || (cmd[7:6] == 2'b00) || (cmd[6] && range_bad);
    endfunction

    function automatic cfg_t apply_write(input cfg_t cfg, input logic [7:0] cmd,
                                         input logic [7:0] hi, input logic [7:0] lo);
        cfg_t r;
        r = cfg;
        if (cmd[6]) begin
            case (cmd[1:0])
                ADDR_WAVE:   r.wave   = lo[1:0];
                ADDR_FREQ:   r.freq   = {hi, lo};
                ADDR_AMP:    r.amp    = {hi[1:0], lo};
                default:     r.offset = {hi[1:0], lo};
            endcase
        end
        return r;
    endfunction

    always_comb begin
        sum_bad    = (chk_acc != uart_data);
        fmt_bad    = frame_format_bad(cmd_q, hi_q, lo_q);
        shadow_nxt = apply_write(shadow, cmd_q, hi_q, lo_q);
    end

    awg_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (data_valid || (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (expired)
    );

    // Capture registers carry frame payload only and need no reset
    always_ff @(posedge clk) begin
        if (data_valid) begin
            case (state)
                ST_CMD: begin
                    cmd_q   <= uart_data;
                    chk_acc <= uart_data;
                end
                ST_HI: begin
                    hi_q    <= uart_data;
                    chk_acc <= chk_acc ^ uart_data;
                end
                ST_LO: begin
                    lo_q    <= uart_data;
                    chk_acc <= chk_acc ^ uart_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shadow     <= CFG_RST;
            live       <= CFG_RST;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            cfg_update <= 1'b0;
            err_code   <= ERR_CHECKSUM;
        end else begin
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            cfg_update <= 1'b0;
            if (data_valid) begin
                case (state)
                    ST_IDLE: if (uart_data == SYNC_BYTE) state <= ST_CMD;
                    ST_CMD:  state <= ST_HI;
                    ST_HI:   state <= ST_LO;
                    ST_LO:   state <= ST_CHK;
                    ST_CHK: begin
                        state <= ST_IDLE;
                        if (sum_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHECKSUM;
                        end else if (fmt_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_FORMAT;
                        end else begin
                            // Commit takes the merged shadow so write+commit lands in one edge
                            frame_ok <= 1'b1;
                            shadow   <= shadow_nxt;
                            if (cmd_q[7]) begin
                                live       <= shadow_nxt;
                                cfg_update <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expired) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end
        end
    end

    assign waveform_type = live.wave;
    assign frequency     = live.freq;
    assign amplitude     = live.amp;
    assign dc_offset     = live.offset;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_awg_cmd_sequencer.sv
// Directed bench for awg_cmd_sequencer with hand-computed frames and expectations.
module tb_awg_cmd_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_data;
    logic        data_valid;
    logic [1:0]  waveform_type;
    logic [15:0] frequency;
    logic [9:0]  amplitude;
    logic [9:0]  dc_offset;
    logic        cfg_update;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    awg_cmd_sequencer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_data     (uart_data),
        .data_valid    (data_valid),
        .waveform_type (waveform_type),
        .frequency     (frequency),
        .amplitude     (amplitude),
        .dc_offset     (dc_offset),
        .cfg_update    (cfg_update),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge, returns at the following negedge
    task automatic send_byte(input logic [7:0] b);
        uart_data  = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        send_byte(k);
    endtask

    initial begin
        rst        = 1'b0;
        uart_data  = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        check("rst_wave",   32'(waveform_type), 32'h0);
        check("rst_freq",   32'(frequency),     32'h0001);
        check("rst_amp",    32'(amplitude),     32'h3FF);
        check("rst_offset", 32'(dc_offset),     32'h200);
        check("rst_busy",   32'(busy),          32'h0);
        check("rst_pulses", 32'({cfg_update, frame_ok, frame_err}), 32'h0);
        check("rst_code",   32'(err_code),      32'h0);

        // 1: shadow write only, then commit-only
        send_byte(8'hA5); send_byte(8'h41); send_byte(8'h12); send_byte(8'h34);
        check("t1_busy", 32'(busy), 32'h1);
        send_byte(8'h67);
        check("t1_ok",     32'(frame_ok),   32'h1);
        check("t1_err",    32'(frame_err),  32'h0);
        check("t1_upd",    32'(cfg_update), 32'h0);
        check("t1_freq",   32'(frequency),  32'h0001);
        check("t1_idle",   32'(busy),       32'h0);
        @(negedge clk);
        check("t1_ok_width", 32'(frame_ok), 32'h0);
        send_frame(8'h80, 8'h00, 8'h00, 8'h80);
        check("t1c_freq", 32'(frequency),  32'h1234);
        check("t1c_upd",  32'(cfg_update), 32'h1);
        check("t1c_ok",   32'(frame_ok),   32'h1);

        // 2: checksum error, then corrected frame with write+commit
        send_frame(8'hC2, 8'h01, 8'hFF, 8'h3D);
        check("t2_err",  32'(frame_err), 32'h1);
        check("t2_ok",   32'(frame_ok),  32'h0);
        check("t2_code", 32'(err_code),  32'h0);
        check("t2_amp",  32'(amplitude), 32'h3FF);
        send_frame(8'hC2, 8'h01, 8'hFF, 8'h3C);
        check("t2c_amp",  32'(amplitude),  32'h1FF);
        check("t2c_upd",  32'(cfg_update), 32'h1);
        check("t2c_err",  32'(frame_err),  32'h0);

        // 3: range and format rejections
        send_frame(8'hC3, 8'h04, 8'h00, 8'hC7);
        check("t3_err",    32'(frame_err), 32'h1);
        check("t3_code",   32'(err_code),  32'h1);
        check("t3_offset", 32'(dc_offset), 32'h200);
        send_frame(8'hC1, 8'h00, 8'h00, 8'hC1);
        check("t3f_code", 32'(err_code),  32'h1);
        check("t3f_err",  32'(frame_err), 32'h1);
        check("t3f_freq", 32'(frequency), 32'h1234);
        send_frame(8'hC4, 8'h00, 8'h00, 8'hC4);
        check("t3c_err",  32'(frame_err), 32'h1);
        check("t3c_code", 32'(err_code),  32'h1);
        send_frame(8'hC3, 8'h03, 8'hFF, 8'h3F);
        check("t3m_offset", 32'(dc_offset), 32'h3FF);
        check("t3m_ok",     32'(frame_ok),  32'h1);

        // 4: timeout one cycle after the gap reaches T
        send_byte(8'hA5); send_byte(8'h41);
        repeat (T - 1) @(negedge clk);
        check("t4_pre_busy", 32'(busy),      32'h1);
        check("t4_pre_err",  32'(frame_err), 32'h0);
        @(negedge clk);
        check("t4_err",  32'(frame_err), 32'h1);
        check("t4_code", 32'(err_code),  32'h2);
        check("t4_busy", 32'(busy),      32'h0);
        send_frame(8'hC0, 8'h00, 8'h02, 8'hC2);
        check("t4_wave", 32'(waveform_type), 32'h2);
        check("t4_ok",   32'(frame_ok),      32'h1);

        // 5: reset mid-frame discards it; trailing bytes fall into IDLE
        send_byte(8'hA5); send_byte(8'h41); send_byte(8'h12);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h34); send_byte(8'h67);
        check("t5_pulses", 32'({cfg_update, frame_ok, frame_err}), 32'h0);
        check("t5_busy",   32'(busy),          32'h0);
        check("t5_wave",   32'(waveform_type), 32'h0);
        check("t5_freq",   32'(frequency),     32'h0001);
        check("t5_amp",    32'(amplitude),     32'h3FF);
        check("t5_offset", 32'(dc_offset),     32'h200);
        check("t5_code",   32'(err_code),      32'h0);

        // 6: noise in IDLE, byte on the exact expiry cycle, SYNC value as payload
        send_byte(8'h00); send_byte(8'h5A); send_byte(8'hFF);
        check("t6_noise_busy", 32'(busy),      32'h0);
        check("t6_noise_err",  32'(frame_err), 32'h0);
        send_byte(8'hA5);
        repeat (T - 1) @(negedge clk);
        send_byte(8'hC1);
        check("t6_exp_busy", 32'(busy),      32'h1);
        check("t6_exp_err",  32'(frame_err), 32'h0);
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hC1);
        check("t6_ok",   32'(frame_ok),   32'h1);
        check("t6_freq", 32'(frequency),  32'hA5A5);
        check("t6_upd",  32'(cfg_update), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
